// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front-end that turns MOSI frames into RAM command words
// and shifts one byte of RAM read data back out on MISO, MSB first.  Rev 1.0
`default_nettype none

module spi_slave_if #(
  parameter int RX_WIDTH = 10,
  parameter int TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
);

  localparam int RXCW = $clog2(RX_WIDTH + 1);
  localparam int TXCW = $clog2(TX_WIDTH);

  localparam logic [RXCW-1:0] C_RX_LAST = RXCW'(RX_WIDTH - 1);
  localparam logic [TXCW-1:0] C_TX_LAST = TXCW'(TX_WIDTH - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHK_CMD   = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  logic [2:0]          r_state;
  logic [RX_WIDTH-2:0] r_shift;
  logic [RXCW-1:0]     r_rx_cnt;
  logic                r_rx_done;
  logic [RX_WIDTH-1:0] r_rx_data;
  logic                r_rx_valid;
  logic                r_rd_addr_seen;
  logic [TX_WIDTH-2:0] r_tx_shift;
  logic [TXCW-1:0]     r_tx_cnt;
  logic                r_tx_busy;
  logic                r_tx_done;
  logic                r_miso;

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_rx_cnt       <= '0;
      r_rx_done      <= 1'b0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_tx_busy      <= 1'b0;
      r_tx_done      <= 1'b0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
      if (SS_n) begin
        // Frame abort: drop everything in flight but keep the read-address history.
        r_state   <= S_IDLE;
        r_rx_cnt  <= '0;
        r_rx_done <= 1'b0;
        r_tx_cnt  <= '0;
        r_tx_busy <= 1'b0;
        r_tx_done <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_CHK_CMD;
          S_CHK_CMD: begin
            r_rx_cnt  <= '0;
            r_rx_done <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
            if (!MOSI)              r_state <= S_WRITE;
            else if (r_rd_addr_seen) r_state <= S_READ_DATA;
            else                    r_state <= S_READ_ADD;
          end
          S_WRITE, S_READ_ADD, S_READ_DATA: begin
            if (!r_rx_done) begin
              r_shift  <= {r_shift[RX_WIDTH-3:0], MOSI};
              r_rx_cnt <= r_rx_cnt + 1'b1;
              if (r_rx_cnt == C_RX_LAST) begin
                r_rx_data  <= {r_shift, MOSI};
                r_rx_valid <= 1'b1;
                r_rx_done  <= 1'b1;
                if (r_state == S_READ_ADD)  r_rd_addr_seen <= 1'b1;
                if (r_state == S_READ_DATA) r_rd_addr_seen <= 1'b0;
              end
            end
            // One byte per frame: r_tx_done blocks reloads while tx_valid stays high.
            if (r_state == S_READ_DATA && r_rx_done) begin
              if (r_tx_busy) begin
                if (r_tx_cnt != '0) begin
                  r_miso     <= r_tx_shift[TX_WIDTH-2];
                  r_tx_shift <= {r_tx_shift[TX_WIDTH-3:0], 1'b0};
                  r_tx_cnt   <= r_tx_cnt - 1'b1;
                end else begin
                  r_tx_busy <= 1'b0;
                  r_tx_done <= 1'b1;
                end
              end else if (!r_tx_done && tx_valid) begin
                r_miso     <= tx_data[TX_WIDTH-1];
                r_tx_shift <= tx_data[TX_WIDTH-2:0];
                r_tx_cnt   <= C_TX_LAST;
                r_tx_busy  <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
